// File: rtl/pixel_lut_rgb.sv
`default_nettype none
// ============================================================================
// pixel_lut_rgb : double-buffered per-channel pixel LUT, bypass/LUT/binarise
// Rev 1.0
// ============================================================================
module pixel_lut_rgb #(
  parameter int DATA_W = 8,
  parameter int CH     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_de,
  input  logic                 in_hsync,
  input  logic                 in_vsync,
  input  logic [CH*DATA_W-1:0] in_pix,
  output logic                 out_de,
  output logic                 out_hsync,
  output logic                 out_vsync,
  output logic [CH*DATA_W-1:0] out_pix,
  input  logic [1:0]           mode,
  input  logic [DATA_W-1:0]    threshold,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_ch,
  input  logic [DATA_W-1:0]    cfg_addr,
  input  logic [DATA_W-1:0]    cfg_data,
  input  logic                 cfg_swap_req,
  output logic                 busy,
  output logic                 bank_active
);

  localparam int DEPTH = 1 << DATA_W;
  localparam int PW    = CH * DATA_W;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic                bank_active_q, bank_active_d;
  logic                pend_q, pend_d;
  logic                vs_prev_q, vs_prev_d;
  logic [1:0]          mode_sh_q, mode_sh_d;
  logic [DATA_W-1:0]   thr_sh_q, thr_sh_d;

  logic [PW-1:0]       s1_pix_q, s1_pix_d;
  logic                s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic                s1_busy_q, s1_busy_d, s1_bank_q, s1_bank_d;
  logic [1:0]          s1_mode_q, s1_mode_d;
  logic [DATA_W-1:0]   s1_thr_q, s1_thr_d;

  logic [PW-1:0]       out_pix_q, out_pix_d;
  logic                out_de_q, out_de_d, out_hs_q, out_hs_d, out_vs_q, out_vs_d;

  logic [CH-1:0]       wr_en0, wr_en1;
  logic [DATA_W-1:0]   wr_addr, wr_data;
  logic [PW-1:0]       lut_pix;
  logic                run, vs_rise;

  assign run     = (state_q == ST_RUN);
  assign vs_rise = in_vsync & ~vs_prev_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bank_active_d = bank_active_q;
    pend_d        = pend_q;
    vs_prev_d     = in_vsync;
    mode_sh_d     = mode_sh_q;
    thr_sh_d      = thr_sh_q;
    wr_en0        = '0;
    wr_en1        = '0;
    wr_addr       = cfg_addr;
    wr_data       = cfg_data;

    if (!run) begin
      wr_en0  = '1;
      wr_en1  = '1;
      wr_addr = cnt_q;
      wr_data = cnt_q;
      cnt_d   = cnt_q + DATA_W'(1);
      if (cnt_q == '1) state_d = ST_RUN;
    end else begin
      // Host writes always target the bank the video path is not reading.
      if (cfg_we) begin
        for (int c = 0; c < CH; c++) begin
          if (cfg_ch == 2'(c)) begin
            if (bank_active_q) wr_en0[c] = 1'b1;
            else               wr_en1[c] = 1'b1;
          end
        end
      end
      if (vs_rise && pend_q) begin
        bank_active_d = ~bank_active_q;
        pend_d        = cfg_swap_req;
      end else if (cfg_swap_req) begin
        pend_d = 1'b1;
      end
    end

    if (vs_rise) begin
      mode_sh_d = mode;
      thr_sh_d  = threshold;
    end

    // Stage 1 carries the post-edge bank and shadow settings with the pixel.
    s1_pix_d  = in_pix;
    s1_de_d   = in_de;
    s1_hs_d   = in_hsync;
    s1_vs_d   = in_vsync;
    s1_busy_d = ~run;
    s1_bank_d = bank_active_d;
    s1_mode_d = mode_sh_d;
    s1_thr_d  = thr_sh_d;

    out_de_d  = s1_de_q;
    out_hs_d  = s1_hs_q;
    out_vs_d  = s1_vs_q;
    out_pix_d = s1_pix_q;
    if (!s1_busy_q) begin
      case (s1_mode_q)
        2'd1:    out_pix_d = lut_pix;
        2'd2:    out_pix_d = (lut_pix[DATA_W-1:0] >= s1_thr_q) ? '1 : '0;
        default: out_pix_d = s1_pix_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      bank_active_q <= 1'b0;
      pend_q        <= 1'b0;
      vs_prev_q     <= 1'b0;
      mode_sh_q     <= 2'd0;
      thr_sh_q      <= '0;
      s1_pix_q      <= '0;
      s1_de_q       <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      s1_busy_q     <= 1'b1;
      s1_bank_q     <= 1'b0;
      s1_mode_q     <= 2'd0;
      s1_thr_q      <= '0;
      out_pix_q     <= '0;
      out_de_q      <= 1'b0;
      out_hs_q      <= 1'b0;
      out_vs_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bank_active_q <= bank_active_d;
      pend_q        <= pend_d;
      vs_prev_q     <= vs_prev_d;
      mode_sh_q     <= mode_sh_d;
      thr_sh_q      <= thr_sh_d;
      s1_pix_q      <= s1_pix_d;
      s1_de_q       <= s1_de_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_busy_q     <= s1_busy_d;
      s1_bank_q     <= s1_bank_d;
      s1_mode_q     <= s1_mode_d;
      s1_thr_q      <= s1_thr_d;
      out_pix_q     <= out_pix_d;
      out_de_q      <= out_de_d;
      out_hs_q      <= out_hs_d;
      out_vs_q      <= out_vs_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [DATA_W-1:0] rd0_q, rd1_q;

    always_ff @(posedge clk) begin
      if (wr_en0[c]) mem0[wr_addr] <= wr_data;
      if (wr_en1[c]) mem1[wr_addr] <= wr_data;
      rd0_q <= mem0[in_pix[c*DATA_W +: DATA_W]];
      rd1_q <= mem1[in_pix[c*DATA_W +: DATA_W]];
    end

    assign lut_pix[c*DATA_W +: DATA_W] = s1_bank_q ? rd1_q : rd0_q;
  end

  assign out_pix     = out_pix_q;
  assign out_de      = out_de_q;
  assign out_hsync   = out_hs_q;
  assign out_vsync   = out_vs_q;
  assign busy        = ~run;
  assign bank_active = bank_active_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_lut_rgb.sv
`default_nettype none
// tb_pixel_lut_rgb : directed stimulus, per-cycle reference model plus literal checks.
module tb_pixel_lut_rgb;
  localparam int DW = 8;
  localparam int CH = 3;
  localparam int PW = CH * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_de = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0;
  logic [PW-1:0] in_pix = '0;
  logic          out_de, out_hsync, out_vsync;
  logic [PW-1:0] out_pix;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] threshold = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = 2'd0;
  logic [DW-1:0] cfg_addr = '0, cfg_data = '0;
  logic          cfg_swap_req = 1'b0;
  logic          busy, bank_active;

  int checks = 0;
  int errors = 0;

  pixel_lut_rgb #(.DATA_W(DW), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_pix(in_pix),
    .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync), .out_pix(out_pix),
    .mode(mode), .threshold(threshold),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_swap_req(cfg_swap_req), .busy(busy), .bank_active(bank_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tables per channel/bank, frame-level state, 2-deep output pipe.
  logic [DW-1:0]  m_lut [CH][2][256];
  int             m_cnt;
  bit             m_busy, m_bank, m_pend, m_vs_prev;
  logic [1:0]     m_mode;
  logic [DW-1:0]  m_thr;
  logic [PW+2:0]  m_p1, m_p2;

  task automatic m_reset();
    m_cnt = 0; m_busy = 1; m_bank = 0; m_pend = 0; m_vs_prev = 0;
    m_mode = 2'd0; m_thr = '0; m_p1 = '0; m_p2 = '0;
  endtask

  task automatic m_step();
    bit            rise, nb, was_busy;
    logic [1:0]    nmode;
    logic [DW-1:0] nthr;
    logic [DW-1:0] l [CH];
    logic [PW-1:0] res;
    rise     = in_vsync && !m_vs_prev;
    was_busy = m_busy;
    nb       = m_bank;
    if (!was_busy && rise && m_pend) nb = !m_bank;
    nmode = rise ? mode : m_mode;
    nthr  = rise ? threshold : m_thr;
    for (int c = 0; c < CH; c++) l[c] = m_lut[c][nb][in_pix[c*DW +: DW]];
    res = in_pix;
    if (!was_busy && nmode == 2'd1)
      for (int c = 0; c < CH; c++) res[c*DW +: DW] = l[c];
    else if (!was_busy && nmode == 2'd2)
      res = (l[0] >= nthr) ? {PW{1'b1}} : {PW{1'b0}};
    if (was_busy) begin
      for (int c = 0; c < CH; c++) begin
        m_lut[c][0][m_cnt] = 8'(m_cnt);
        m_lut[c][1][m_cnt] = 8'(m_cnt);
      end
      if (m_cnt == 255) m_busy = 0;
      m_cnt++;
    end else begin
      if (cfg_we && int'(cfg_ch) < CH) m_lut[int'(cfg_ch)][!m_bank][cfg_addr] = cfg_data;
      if (rise && m_pend) m_pend = cfg_swap_req;
      else if (cfg_swap_req) m_pend = 1;
    end
    m_bank = nb; m_mode = nmode; m_thr = nthr; m_vs_prev = in_vsync;
    m_p2 = m_p1;
    m_p1 = {in_vsync, in_hsync, in_de, res};
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("cycle_outputs", 32'({out_vsync, out_hsync, out_de, out_pix}), 32'(m_p2));
      check("cycle_busy", 32'(busy), 32'(m_busy));
      check("cycle_bank", 32'(bank_active), 32'(m_bank));
    end
  end

  task automatic send_pix(input string name, input logic [PW-1:0] pix, input logic [PW-1:0] exp);
    @(negedge clk); in_pix = pix; in_de = 1'b1;
    @(negedge clk); in_pix = '0; in_de = 1'b0;
    check({name, "_de_early"}, 32'(out_de), 32'd0);
    @(negedge clk);
    check({name, "_pix"}, 32'(out_pix), 32'(exp));
    check({name, "_de"}, 32'(out_de), 32'd1);
  endtask

  task automatic vsync_pulse();
    @(negedge clk); in_vsync = 1'b1;
    @(negedge clk); in_vsync = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check(name, 32'(n), 32'd256);
    @(negedge clk);
  endtask

  initial begin
    in_pix = 24'h654321;
    repeat (2) @(negedge clk);
    check("reset_out_pix", 32'(out_pix), 32'd0);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_bank", 32'(bank_active), 32'd0);
    rst_n = 1'b1;
    count_busy("busy_cycles");
    check("bypass_during_init", 32'(out_pix), 32'h654321);
    in_pix = '0;
    send_pix("bypass_run", 24'h0A0B0C, 24'h0A0B0C);

    // LUT mode with identity tables; sync pulses delayed by 2
    mode = 2'd1;
    vsync_pulse();
    send_pix("identity", 24'h123456, 24'h123456);
    @(negedge clk); in_hsync = 1'b1;
    @(negedge clk); in_hsync = 1'b0;
    check("hs_early", 32'(out_hsync), 32'd0);
    @(negedge clk); check("hs_delayed", 32'(out_hsync), 32'd1);
    @(negedge clk); check("hs_end", 32'(out_hsync), 32'd0);
    @(negedge clk); in_vsync = 1'b1;
    @(negedge clk); in_vsync = 1'b0;
    check("vs_early", 32'(out_vsync), 32'd0);
    @(negedge clk); check("vs_delayed", 32'(out_vsync), 32'd1);

    // Load inverted ch0 table into the inactive bank, then swap at vsync
    for (int x = 0; x < 256; x++) begin
      @(negedge clk); cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 8'(x); cfg_data = 8'(255 - x);
    end
    @(negedge clk); cfg_we = 1'b0; cfg_swap_req = 1'b1;
    @(negedge clk); cfg_swap_req = 1'b0;
    send_pix("pre_swap", 24'h000010, 24'h000010);
    check("bank_pre_swap", 32'(bank_active), 32'd0);
    vsync_pulse();
    check("bank_post_swap", 32'(bank_active), 32'd1);
    send_pix("post_swap", 24'h000010, 24'h0000EF);

    // Shadowed mode/threshold change takes effect only at the next vsync
    @(negedge clk); cfg_swap_req = 1'b1;
    @(negedge clk); cfg_swap_req = 1'b0; mode = 2'd2; threshold = 8'h80;
    send_pix("shadow_hold", 24'h000010, 24'h0000EF);
    vsync_pulse();
    check("bank_back", 32'(bank_active), 32'd0);
    send_pix("bin_7f", 24'h00007F, 24'h000000);
    send_pix("bin_80", 24'h000080, 24'hFFFFFF);
    send_pix("bin_ch0_only", 24'h00FF7F, 24'h000000);

    // Swap request on the boundary cycle defers to the following boundary
    mode = 2'd1;
    @(negedge clk); in_vsync = 1'b1; cfg_swap_req = 1'b1;
    @(negedge clk); in_vsync = 1'b0; cfg_swap_req = 1'b0;
    check("bank_no_toggle_on_req", 32'(bank_active), 32'd0);
    @(negedge clk); in_vsync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 8'h20; cfg_data = 8'h55;
    @(negedge clk); in_vsync = 1'b0; cfg_we = 1'b0;
    check("bank_deferred_toggle", 32'(bank_active), 32'd1);
    send_pix("boundary_write", 24'h000020, 24'h000055);
    send_pix("boundary_neighbour", 24'h000021, 24'h0000DE);

    // Asynchronous reset in the middle of INIT
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; in_pix = 24'hA5A5A5; in_de = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    check("pre_reset_pix", 32'(out_pix), 32'hA5A5A5);
    rst_n = 1'b0;
    #1;
    check("async_reset_pix", 32'(out_pix), 32'd0);
    check("async_reset_de", 32'(out_de), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    count_busy("busy_cycles_restart");
    check("bank_after_restart", 32'(bank_active), 32'd0);
    in_de = 1'b0; in_pix = '0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
